// File: rtl/arm7tdmi_imm_encoder_if.sv
// Request/response bundle for the ARM rotate-immediate encoder.
interface arm7tdmi_imm_encoder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_value;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_found;
    logic [7:0]  rsp_imm8;
    logic [3:0]  rsp_rot4;
    logic        rsp_carry_def;
    logic        rsp_carry;
    logic        rsp_invert;

    modport master (
        output req_valid, req_value, rsp_ready,
        input  req_ready, rsp_valid, rsp_found, rsp_imm8, rsp_rot4,
               rsp_carry_def, rsp_carry, rsp_invert
    );

    modport slave (
        input  req_valid, req_value, rsp_ready,
        output req_ready, rsp_valid, rsp_found, rsp_imm8, rsp_rot4,
               rsp_carry_def, rsp_carry, rsp_invert
    );
endinterface

// File: rtl/arm7tdmi_imm_encoder.sv
// Sequential search for an ARM operand-2 immediate {rot4, imm8}, one rotation per cycle.
// Define ARM_IMM_ENC_INV_EN to also search ~value (MVN/BIC form) at each rotation.
module arm7tdmi_imm_encoder #(
    parameter int unsigned MAX_ROT = 15
) (
    input logic                    clk,
    input logic                    rst,
    arm7tdmi_imm_encoder_if.slave  bus
);

    localparam logic [3:0] LastRot = 4'(MAX_ROT);

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_t;

    state_t      r_state;
    logic [31:0] r_value;
    logic [3:0]  r_rot_cnt;
    logic        r_req_ready;
    logic        r_rsp_valid;
    logic        r_found;
    logic [7:0]  r_imm8;
    logic [3:0]  r_rot4;
    logic        r_carry_def;
    logic        r_carry;
    logic        r_invert;

    logic [4:0]  w_shamt;
    logic [63:0] w_dbl;
    logic [31:0] w_cand;
    logic        w_hit;
    logic        w_hit_any;
    logic        w_use_inv;
    logic [7:0]  w_enc_imm8;
    logic        w_enc_msb;
    logic        w_last;
    logic        w_rot_nz;

    // ROL(value, 2*rot) taken as the upper half of the doubled word shifted left.
    assign w_shamt  = {r_rot_cnt, 1'b0};
    assign w_dbl    = {r_value, r_value} << w_shamt;
    assign w_cand   = w_dbl[63:32];
    assign w_hit    = (w_cand[31:8] == 24'd0);
    assign w_last   = (r_rot_cnt == LastRot);
    assign w_rot_nz = (r_rot_cnt != 4'd0);

`ifdef ARM_IMM_ENC_INV_EN
    logic [63:0] w_inv_dbl;
    logic [31:0] w_inv_cand;
    logic        w_inv_hit;

    assign w_inv_dbl  = {~r_value, ~r_value} << w_shamt;
    assign w_inv_cand = w_inv_dbl[63:32];
    assign w_inv_hit  = (w_inv_cand[31:8] == 24'd0);
    // Plain encoding wins over the inverted one at the same rotation.
    assign w_hit_any  = w_hit | w_inv_hit;
    assign w_use_inv  = ~w_hit & w_inv_hit;
    assign w_enc_imm8 = w_use_inv ? w_inv_cand[7:0] : w_cand[7:0];
    assign w_enc_msb  = w_use_inv ? ~r_value[31] : r_value[31];
`else
    assign w_hit_any  = w_hit;
    assign w_use_inv  = 1'b0;
    assign w_enc_imm8 = w_cand[7:0];
    assign w_enc_msb  = r_value[31];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_value     <= 32'd0;
            r_rot_cnt   <= 4'd0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_found     <= 1'b0;
            r_imm8      <= 8'd0;
            r_rot4      <= 4'd0;
            r_carry_def <= 1'b0;
            r_carry     <= 1'b0;
            r_invert    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_value     <= bus.req_value;
                        r_rot_cnt   <= 4'd0;
                        r_req_ready <= 1'b0;
                        r_state     <= StSearch;
                    end
                end
                StSearch: begin
                    if (w_hit_any) begin
                        r_found     <= 1'b1;
                        r_imm8      <= w_enc_imm8;
                        r_rot4      <= r_rot_cnt;
                        r_carry_def <= w_rot_nz;
                        r_carry     <= w_rot_nz & w_enc_msb;
                        r_invert    <= w_use_inv;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StDone;
                    end else if (w_last) begin
                        r_found     <= 1'b0;
                        r_imm8      <= 8'd0;
                        r_rot4      <= 4'd0;
                        r_carry_def <= 1'b0;
                        r_carry     <= 1'b0;
                        r_invert    <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_rot_cnt <= r_rot_cnt + 4'd1;
                    end
                end
                StDone: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= StIdle;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_found     = r_found;
    assign bus.rsp_imm8      = r_imm8;
    assign bus.rsp_rot4      = r_rot4;
    assign bus.rsp_carry_def = r_carry_def;
    assign bus.rsp_carry     = r_carry;
`ifdef ARM_IMM_ENC_INV_EN
    assign bus.rsp_invert    = r_invert;
`else
    assign bus.rsp_invert    = 1'b0;
`endif

endmodule

// File: tb/tb_arm7tdmi_imm_encoder.sv
// Scoreboard bench for arm7tdmi_imm_encoder: directed vectors, queued expectations, negedge monitor.
module tb_arm7tdmi_imm_encoder;

    typedef struct {
        logic        found;
        logic [7:0]  imm8;
        logic [3:0]  rot4;
        logic        cdef;
        logic        carry;
        logic        inv;
        int          lat;
        int          acc_cyc;
    } exp_t;

    logic clk;
    logic rst;
    arm7tdmi_imm_encoder_if bus();

    arm7tdmi_imm_encoder #(.MAX_ROT(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    bit   seen     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare every cycle the response is shown; pop on handshake.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - q[0].acc_cyc), 32'(q[0].lat));
                    seen = 1;
                end
                chk("found",     32'(bus.rsp_found),     32'(q[0].found));
                chk("imm8",      32'(bus.rsp_imm8),      32'(q[0].imm8));
                chk("rot4",      32'(bus.rsp_rot4),      32'(q[0].rot4));
                chk("carry_def", 32'(bus.rsp_carry_def), 32'(q[0].cdef));
                chk("carry",     32'(bus.rsp_carry),     32'(q[0].carry));
                chk("invert",    32'(bus.rsp_invert),    32'(q[0].inv));
                chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
                if (bus.rsp_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic send(input logic [31:0] v, input logic f, input logic [7:0] i8,
                        input logic [3:0] r4, input logic cd, input logic c,
                        input logic inv, input int lat);
        exp_t e;
        int   n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_value = v;
        n = 0;
        while (!bus.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk("req_ready_timeout", 32'd0, 32'd1);
            bus.req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.found = f; e.imm8 = i8; e.rot4 = r4; e.cdef = cd; e.carry = c;
            e.inv = inv; e.lat = lat; e.acc_cyc = cyc;
            q.push_back(e);
            bus.req_valid = 1'b0;
            bus.req_value = 32'hDEAD_BEEF;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("drain_timeout", 32'(q.size()), 32'd0);
            q.delete();
            seen = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_value = 32'd0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_found",     32'(bus.rsp_found), 32'd0);
        chk("rst_imm8",      32'(bus.rsp_imm8),  32'd0);
        chk("rst_rot4",      32'(bus.rsp_rot4),  32'd0);
        rst = 1'b0;

        send(32'h0000_00FF, 1'b1, 8'hFF, 4'd0,  1'b0, 1'b0, 1'b0, 1);
        drain();
        send(32'hF000_000F, 1'b1, 8'hFF, 4'd2,  1'b1, 1'b1, 1'b0, 3);
        drain();
        send(32'h0000_03FC, 1'b1, 8'hFF, 4'd15, 1'b1, 1'b0, 1'b0, 16);
        drain();
        send(32'h0000_0101, 1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 16);
        drain();
        send(32'h0000_0000, 1'b1, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 1);
        drain();
`ifdef ARM_IMM_ENC_INV_EN
        send(32'hFFFF_FF00, 1'b1, 8'hFF, 4'd0,  1'b0, 1'b0, 1'b1, 1);
`else
        send(32'hFFFF_FF00, 1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 1'b0, 16);
`endif
        drain();

        // Backpressure: hold the result for 5 cycles, then accept.
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        send(32'hFF00_0000, 1'b1, 8'hFF, 4'd4, 1'b1, 1'b1, 1'b0, 5);
        n = 0;
        while (!bus.rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("bp_valid_timeout", 32'd0, 32'd1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_req_ready_after", 32'(bus.req_ready), 32'd1);
        chk("bp_rsp_valid_after", 32'(bus.rsp_valid), 32'd0);
        drain();

        // Reset in the middle of a search discards the pending result.
        send(32'h0000_03FC, 1'b1, 8'hFF, 4'd15, 1'b1, 1'b0, 1'b0, 16);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        q.delete();
        seen = 0;
        #2;
        chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_found",     32'(bus.rsp_found), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        send(32'h0000_0000, 1'b1, 8'h00, 4'd0, 1'b0, 1'b0, 1'b0, 1);
        drain();
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
